// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin arbiter sharing one serial emitter among NUM_REQ requesters.
// Optional SEND/DRAIN watchdog with sticky timeout_err is enabled by defining TX_TIMEOUT_EN.
module serial_tx_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 25,
  parameter int unsigned IDX_WIDTH  = 2,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                          fast_clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         emit_data,
  output logic                          emit_start,
  input  logic                          emit_done,
  output logic [IDX_WIDTH-1:0]          grant_idx,
  output logic                          busy,
  output logic                          timeout_err
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || (2 ** IDX_WIDTH) < NUM_REQ || TIMEOUT < 1) begin : g_cfg_check
    $error("serial_tx_arbiter: invalid parameter combination");
  end

  typedef enum logic [1:0] {IDLE, SEND, ACK, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [IDX_WIDTH-1:0]    ptr_q, ptr_d;
  logic [IDX_WIDTH-1:0]    grant_q, grant_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [IDX_WIDTH-1:0]    winner;
  logic [IDX_WIDTH-1:0]    cand;
  logic                    win_valid;
  logic                    expired;

  // First requester after the pointer, wrapping, so the last winner ranks lowest.
  always_comb begin
    winner    = '0;
    win_valid = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_WIDTH'((32'(ptr_q) + k) % NUM_REQ);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        winner    = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = SEND;
          ptr_d   = winner;
          grant_d = winner;
          data_d  = req_data[winner*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      SEND: begin
        if (emit_done) state_d = ACK;
        else if (expired) state_d = DRAIN;
      end
      ACK:   state_d = DRAIN;
      DRAIN: begin
        // A done still high from the last frame must not complete the next one.
        if (!emit_done || expired) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= IDX_WIDTH'(NUM_REQ - 1);
      grant_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    ack = '0;
    if (state_q == ACK) ack[grant_q] = 1'b1;
  end

  assign emit_data  = data_q;
  assign emit_start = (state_q == SEND);
  assign grant_idx  = grant_q;
  assign busy       = (state_q != IDLE);

`ifdef TX_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             err_q, err_d;

  assign expired = (tcnt_q == CNT_W'(TIMEOUT - 1));

  // Counter restarts on every state change, so it measures time spent in SEND or DRAIN.
  always_comb begin
    tcnt_d = '0;
    if ((state_q == SEND || state_q == DRAIN) && state_d == state_q) tcnt_d = tcnt_q + CNT_W'(1);
    err_d = err_q | (state_q == SEND && state_d == DRAIN);
  end

  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      err_q  <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  assign expired     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter: behavioural emitter, transaction-level reference model
// checked every cycle, and literal expectations per scenario.
module tb_serial_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 25;
  localparam int IW = 2;
  localparam int TO = 64;
`ifdef TX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             fast_clk = 1'b0;
  logic             reset = 1'b0;
  logic [NR-1:0]    req = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    ack;
  logic [DW-1:0]    emit_data;
  logic             emit_start;
  logic             emit_done;
  logic [IW-1:0]    grant_idx;
  logic             busy;
  logic             timeout_err;

  int checks = 0;
  int failures = 0;

  always #5 fast_clk = ~fast_clk;

  serial_tx_arbiter #(
    .NUM_REQ(NR),
    .DATA_WIDTH(DW),
    .IDX_WIDTH(IW),
    .TIMEOUT(TO)
  ) dut (
    .fast_clk(fast_clk),
    .reset(reset),
    .req(req),
    .req_data(req_data),
    .ack(ack),
    .emit_data(emit_data),
    .emit_start(emit_start),
    .emit_done(emit_done),
    .grant_idx(grant_idx),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Emitter: raises done done_delay cycles into a frame, releases it hold_extra cycles after start drops.
  int            done_delay = 3;
  int            hold_extra = 0;
  bit            never_done = 1'b0;
  int            em_cnt = 0;
  int            em_hold = 0;
  logic [DW-1:0] col_log[$];

  always @(negedge fast_clk or posedge reset) begin
    if (reset) begin
      emit_done = 1'b0;
      em_cnt    = 0;
      em_hold   = 0;
    end else if (emit_start && !emit_done) begin
      em_cnt++;
      if (!never_done && em_cnt >= done_delay) begin
        emit_done = 1'b1;
        col_log.push_back(emit_data);
      end
    end else if (!emit_start && emit_done) begin
      if (em_hold >= hold_extra) begin
        emit_done = 1'b0;
        em_hold   = 0;
        em_cnt    = 0;
      end else begin
        em_hold++;
      end
    end
  end

  // Reference model: one transfer at a time; a transfer is sending, acknowledging or waiting for done to clear.
  bit            m_send = 1'b0;
  bit            m_ack = 1'b0;
  bit            m_drain = 1'b0;
  bit            m_err = 1'b0;
  int            m_ptr = NR - 1;
  int            m_grant = 0;
  int            m_time = 0;
  int            m_c;
  bit            m_found;
  logic [DW-1:0] m_word = '0;

  always @(posedge fast_clk or posedge reset) begin
    if (reset) begin
      m_send = 1'b0; m_ack = 1'b0; m_drain = 1'b0; m_err = 1'b0;
      m_ptr = NR - 1; m_grant = 0; m_time = 0; m_word = '0;
    end else if (m_send) begin
      m_time++;
      if (emit_done) begin
        m_send = 1'b0; m_ack = 1'b1;
      end else if (TO_EN && m_time == TO) begin
        m_send = 1'b0; m_drain = 1'b1; m_err = 1'b1; m_time = 0;
      end
    end else if (m_ack) begin
      m_ack = 1'b0; m_drain = 1'b1; m_time = 0;
    end else if (m_drain) begin
      m_time++;
      if (!emit_done || (TO_EN && m_time == TO)) m_drain = 1'b0;
    end else if (req != '0) begin
      m_found = 1'b0;
      for (int k = 1; k <= NR; k++) begin
        m_c = (m_ptr + k) % NR;
        if (!m_found && req[m_c]) begin
          m_found = 1'b1;
          m_grant = m_c;
        end
      end
      m_ptr  = m_grant;
      m_word = req_data[m_grant*DW +: DW];
      m_send = 1'b1;
      m_time = 0;
    end
  end

  int   cyc = 0;
  int   ack_log[$];
  int   ack_cyc[$];
  int   rise_cyc[$];
  logic prev_start = 1'b0;

  always @(negedge fast_clk) begin
    cyc++;
    if (!reset) begin
      check("emit_start", 64'(emit_start), 64'(m_send));
      check("busy", 64'(busy), 64'(m_send | m_ack | m_drain));
      check("ack", 64'(ack), m_ack ? (64'd1 << m_grant) : 64'd0);
      check("grant_idx", 64'(grant_idx), 64'(m_grant));
      check("emit_data", 64'(emit_data), 64'(m_word));
      check("timeout_err", 64'(timeout_err), 64'(m_err));
      for (int i = 0; i < NR; i++) begin
        if (ack[i]) begin
          ack_log.push_back(i);
          ack_cyc.push_back(cyc);
        end
      end
      if (emit_start && !prev_start) rise_cyc.push_back(cyc);
    end
    prev_start = emit_start;
  end

  task automatic tick();
    @(negedge fast_clk);
    req = req & ~ack;
  endtask

  task automatic do_reset();
    @(negedge fast_clk);
    reset = 1'b1;
    req   = '0;
    repeat (2) @(negedge fast_clk);
    reset = 1'b0;
  endtask

  task automatic wait_acks(input int n, input int budget, input string name);
    int b;
    b = 0;
    while (ack_log.size() < n && b < budget) begin
      tick();
      b++;
    end
    check({name, "_ack_in_time"}, 64'(ack_log.size() >= n), 64'd1);
  endtask

  int a0, c0, r0;

  initial begin
    do_reset();
    tick();
    check("rst_emit_start", 64'(emit_start), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_grant", 64'(grant_idx), 64'd0);
    check("rst_data", 64'(emit_data), 64'd0);
    check("rst_err", 64'(timeout_err), 64'd0);

    // Single requester
    a0 = ack_log.size(); c0 = col_log.size();
    req_data[0*DW +: DW] = 25'd3461;
    req = 4'b0001;
    tick();
    check("t1_start_latency", 64'(emit_start), 64'd1);
    check("t1_emit_data", 64'(emit_data), 64'd3461);
    wait_acks(a0 + 1, 30, "t1");
    repeat (10) tick();
    check("t1_ack_idx", 64'(ack_log[a0]), 64'd0);
    check("t1_ack_once", 64'(ack_log.size()), 64'(a0 + 1));
    check("t1_collected", 64'(col_log[c0]), 64'd3461);

    // Round-robin with all requesters
    do_reset();
    a0 = ack_log.size(); c0 = col_log.size();
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = DW'(i + 1);
    req = 4'b1111;
    wait_acks(a0 + 4, 80, "t2");
    for (int i = 0; i < NR; i++) begin
      check("t2_ack_order", 64'(ack_log[a0 + i]), 64'(i));
      check("t2_collected", 64'(col_log[c0 + i]), 64'(i + 1));
    end
    repeat (4) tick();

    // Fairness wrap: 3 granted last, so 0 precedes 3
    a0 = ack_log.size();
    req = 4'b1001;
    wait_acks(a0 + 2, 40, "t3");
    check("t3_first", 64'(ack_log[a0]), 64'd0);
    check("t3_second", 64'(ack_log[a0 + 1]), 64'd3);
    repeat (4) tick();

    // Stale done held 5 cycles after start falls
    do_reset();
    hold_extra = 5;
    a0 = ack_cyc.size(); r0 = rise_cyc.size();
    req = 4'b0011;
    wait_acks(ack_log.size() + 2, 60, "t4");
    check("t4_ack_to_next_start", 64'(rise_cyc[r0 + 1] - ack_cyc[a0]), 64'd7);
    hold_extra = 0;
    repeat (10) tick();

    // Reset mid-SEND
    do_reset();
    done_delay = 20;
    req_data[1*DW +: DW] = 25'h1FF_FFFF;
    a0 = ack_log.size();
    req = 4'b0010;
    repeat (10) tick();
    check("t5_sending", 64'(emit_start), 64'd1);
    check("t5_data", 64'(emit_data), 64'h1FF_FFFF);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_start", 64'(emit_start), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_ack", 64'(ack), 64'd0);
    done_delay = 3;
    req = 4'b0111;
    @(negedge fast_clk);
    reset = 1'b0;
    check("t5_no_ack", 64'(ack_log.size()), 64'(a0));
    wait_acks(a0 + 1, 30, "t5");
    check("t5_first_after_reset", 64'(ack_log[a0]), 64'd0);
    repeat (30) tick();
    req = '0;
    repeat (10) tick();

    // Emitter never completes
    do_reset();
    never_done = 1'b1;
    a0 = ack_log.size();
    req = 4'b0001;
    repeat (3) tick();
    req = '0;
    repeat (75) tick();
`ifdef TX_TIMEOUT_EN
    check("t6_err", 64'(timeout_err), 64'd1);
    check("t6_idle", 64'(busy), 64'd0);
    check("t6_no_ack", 64'(ack_log.size()), 64'(a0));
`else
    check("t6_busy", 64'(busy), 64'd1);
    check("t6_still_start", 64'(emit_start), 64'd1);
    check("t6_err_zero", 64'(timeout_err), 64'd0);
`endif
    never_done = 1'b0;
    do_reset();
    tick();
    check("t6_err_cleared", 64'(timeout_err), 64'd0);
    check("t6_idle_after_rst", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", checks, failures);
    $fatal(1);
  end

endmodule
